// File: rtl/dijkstra_pkg.sv
// Shared definitions for the Dijkstra front end: edge slot geometry,
// edge field offsets and the loader state encoding.
package dijkstra_pkg;

    // Geometry of one packed edge slot and of the full edge-list bus.
    localparam int EDGE_W        = 12;
    localparam int SLOTS         = 256;
    localparam int DATA_W        = SLOTS * EDGE_W;
    localparam int MAX_EDGES_DEF = 255;

    // Field layout inside one edge word.
    localparam int FIELD_W    = 4;
    localparam int PARENT_LSB = 0;
    localparam int CHILD_LSB  = 4;
    localparam int WEIGHT_LSB = 8;

    // Loader state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // Extract one 4-bit field from an edge word.
    function automatic logic [FIELD_W-1:0] edge_field(
        input logic [EDGE_W-1:0] edge_word,
        input int                lsb
    );
        return edge_word[lsb +: FIELD_W];
    endfunction

endpackage : dijkstra_pkg

// File: rtl/dijkstra_edge_loader.sv
// Edge loader: collects edges from a valid/ready stream into the packed
// 3072-bit edge-list bus and hands the finished graph to the Dijkstra core.
// Optional range check enabled by defining DIJKSTRA_EDGE_RANGE_CHECK_EN:
// edges with parent>=n or child>=n are acknowledged, dropped and flag err.
module dijkstra_edge_loader
    import dijkstra_pkg::*;
#(
    parameter int MAX_EDGES = MAX_EDGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        n_in,
    input  logic              edge_valid,
    output logic              edge_ready,
    input  logic [11:0]       edge_in,
    input  logic              edge_last,
    output logic [3:0]        n,
    output logic [7:0]        e,
    output logic [DATA_W-1:0] data,
    output logic              valid_out,
    input  logic              ready,
    output logic              full,
    output logic              err
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic          r_edge_ready;
    logic          w_edge_ready_next;
    logic          r_valid_out;
    logic          w_valid_out_next;
    logic [3:0]    r_n;
    logic [3:0]    w_n_next;
    logic [7:0]    r_e;
    logic [7:0]    w_e_next;
    logic          r_full;
    logic          w_full_next;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
    logic          r_err;
    logic          w_err_next;
`endif

    logic          w_accept;
    logic          w_keep;
    logic          w_store;
    logic          w_clear;
    logic [8:0]    w_e_inc;
    logic          w_hit_max;

    // A beat is taken only while in LOAD with the registered ready high.
    assign w_accept  = (r_state == LOAD) && r_edge_ready && edge_valid;
    // A new graph wipes the previous slots the same edge that latches n.
    assign w_clear   = (r_state == IDLE) && start;
    assign w_e_inc   = {1'b0, r_e} + 9'd1;

`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
    // Both endpoints must name an existing node; n==0 rejects everything.
    assign w_keep = (edge_field(edge_in, PARENT_LSB) < r_n) &&
                    (edge_field(edge_in, CHILD_LSB)  < r_n);
`else
    assign w_keep = 1'b1;
`endif

    assign w_store   = w_accept && w_keep;
    // Capacity is only reached by an edge that is actually stored.
    assign w_hit_max = w_store && (w_e_inc == 9'(MAX_EDGES));

    // State register; reset abandons any graph in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-value logic for all control/count registers.
    always_comb begin
        w_state_next      = r_state;
        w_edge_ready_next = r_edge_ready;
        w_valid_out_next  = r_valid_out;
        w_n_next          = r_n;
        w_e_next          = r_e;
        w_full_next       = r_full;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
        w_err_next        = r_err;
`endif
        case (r_state)
            IDLE: begin
                w_edge_ready_next = 1'b0;
                w_valid_out_next  = 1'b0;
                if (start) begin
                    w_state_next      = LOAD;
                    w_n_next          = n_in;
                    w_e_next          = 8'd0;
                    w_full_next       = 1'b0;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
                    w_err_next        = 1'b0;
`endif
                    w_edge_ready_next = 1'b1;
                end
            end
            LOAD: begin
                if (w_accept) begin
                    if (w_store) begin
                        w_e_next = w_e_inc[7:0];
                    end
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
                    if (!w_keep) begin
                        w_err_next = 1'b1;
                    end
`endif
                    // edge_last wins over capacity so full stays 0 when both hit.
                    if (edge_last) begin
                        w_state_next      = DONE;
                        w_edge_ready_next = 1'b0;
                        w_valid_out_next  = 1'b1;
                    end else if (w_hit_max) begin
                        w_state_next      = DONE;
                        w_edge_ready_next = 1'b0;
                        w_valid_out_next  = 1'b1;
                        w_full_next       = 1'b1;
                    end
                end
            end
            DONE: begin
                w_edge_ready_next = 1'b0;
                if (ready) begin
                    w_state_next     = IDLE;
                    w_valid_out_next = 1'b0;
                end
            end
            default: begin
                w_state_next      = IDLE;
                w_edge_ready_next = 1'b0;
                w_valid_out_next  = 1'b0;
            end
        endcase
    end

    // Registered control and count outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_edge_ready <= 1'b0;
            r_valid_out  <= 1'b0;
            r_n          <= 4'd0;
            r_e          <= 8'd0;
            r_full       <= 1'b0;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_edge_ready <= w_edge_ready_next;
            r_valid_out  <= w_valid_out_next;
            r_n          <= w_n_next;
            r_e          <= w_e_next;
            r_full       <= w_full_next;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
            r_err        <= w_err_next;
`endif
        end
    end

    // One register per usable slot; slots past MAX_EDGES are hard zero.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
        if (gi < MAX_EDGES) begin : g_used
            logic [EDGE_W-1:0] r_slot;

            // Slot gi captures the stored edge when the pre-increment count equals gi.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_slot <= '0;
                end else if (w_clear) begin
                    r_slot <= '0;
                end else if (w_store && (r_e == 8'(gi))) begin
                    r_slot <= edge_in;
                end
            end

            assign data[gi*EDGE_W +: EDGE_W] = r_slot;
        end else begin : g_unused
            assign data[gi*EDGE_W +: EDGE_W] = '0;
        end
    end

    assign edge_ready = r_edge_ready;
    assign valid_out  = r_valid_out;
    assign n          = r_n;
    assign e          = r_e;
    assign full       = r_full;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

endmodule : dijkstra_edge_loader

// File: tb/tb_dijkstra_edge_loader.sv
// Self-checking bench for dijkstra_edge_loader: a graph-level reference model
// (phase, edge list, counts) is compared with the DUT on every falling edge,
// alongside a few hand-computed expectations for directed scenarios.
// Honors DIJKSTRA_EDGE_RANGE_CHECK_EN the same way as the design.
module tb_dijkstra_edge_loader;
    import dijkstra_pkg::*;

    localparam int MAXE = 255;
`ifdef DIJKSTRA_EDGE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        n_in = 4'd0;
    logic              edge_valid = 1'b0;
    logic              edge_ready;
    logic [11:0]       edge_in = 12'd0;
    logic              edge_last = 1'b0;
    logic [3:0]        n;
    logic [7:0]        e;
    logic [DATA_W-1:0] data;
    logic              valid_out;
    logic              ready = 1'b0;
    logic              full;
    logic              err;

    int checks = 0;
    int failures = 0;

    dijkstra_edge_loader #(.MAX_EDGES(MAXE)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_in       (n_in),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .edge_in    (edge_in),
        .edge_last  (edge_last),
        .n          (n),
        .e          (e),
        .data       (data),
        .valid_out  (valid_out),
        .ready      (ready),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (graph level) ----------------
    // phase: 0 = waiting for start, 1 = collecting edges, 2 = graph offered
    bit          m_live = 1'b0;
    int          m_phase;
    int          m_n;
    int          m_e;
    bit          m_full;
    bit          m_err;
    logic [11:0] m_slot [SLOTS];

    always @(posedge clk) begin
        if (!reset) begin
            m_live  = 1'b1;
            m_phase = 0;
            m_n     = 0;
            m_e     = 0;
            m_full  = 1'b0;
            m_err   = 1'b0;
            for (int k = 0; k < SLOTS; k++) m_slot[k] = 12'd0;
        end else if (m_live) begin
            if (m_phase == 0) begin
                if (start) begin
                    m_n = int'(n_in);
                    m_e = 0;
                    m_full = 1'b0;
                    m_err = 1'b0;
                    for (int k = 0; k < SLOTS; k++) m_slot[k] = 12'd0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (edge_valid) begin
                    int  p;
                    int  c;
                    bit  drop;
                    p = int'(edge_in[3:0]);
                    c = int'(edge_in[7:4]);
                    drop = RC && (p >= m_n || c >= m_n);
                    if (drop) m_err = 1'b1;
                    else begin
                        m_slot[m_e] = edge_in;
                        m_e = m_e + 1;
                    end
                    if (edge_last) m_phase = 2;
                    else if (m_e == MAXE) begin
                        m_phase = 2;
                        m_full = 1'b1;
                    end
                end
            end else begin
                if (ready) m_phase = 0;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            int first_bad;
            check("edge_ready", 64'(edge_ready), 64'(m_phase == 1));
            check("valid_out", 64'(valid_out), 64'(m_phase == 2));
            check("n", 64'(n), 64'(m_n));
            check("e", 64'(e), 64'(m_e));
            check("full", 64'(full), 64'(m_full));
            check("err", 64'(err), 64'(m_err));
            first_bad = -1;
            for (int k = 0; k < SLOTS; k++) begin
                if (first_bad < 0 && data[k*EDGE_W +: EDGE_W] !== m_slot[k]) first_bad = k;
            end
            if (first_bad < 0) check("data", 64'd0, 64'd0 + 64'(first_bad < 0) - 64'd1);
            else check($sformatf("data_slot%0d", first_bad),
                       64'(data[first_bad*EDGE_W +: EDGE_W]), 64'(m_slot[first_bad]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_graph(input logic [3:0] nn);
        start = 1'b1;
        n_in  = nn;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [11:0] w, input bit last, input int bubbles);
        bit acc;
        for (int b = 0; b < bubbles; b++) begin
            start = 1'($urandom_range(0, 1));
            tick();
        end
        start      = 1'b0;
        edge_valid = 1'b1;
        edge_in    = w;
        edge_last  = last;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = edge_ready;
            tick();
        end
        if (!acc) check("edge_accept_timeout", 64'd0, 64'd1);
        edge_valid = 1'b0;
        edge_last  = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            @(negedge clk);
            seen = valid_out;
        end
        if (!seen) check("valid_out_timeout", 64'd0, 64'd1);
    endtask

    task automatic handoff(input int delay);
        @(posedge clk);
        #1;
        for (int d = 0; d < delay; d++) begin
            start = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        $display("graph handoff n=%0d e=%0d full=%0d err=%0d", n, e, full, err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_e", 64'(e), 64'd0);
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_data_any", 64'(|data), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Basic load
        begin_graph(4'd4);
        send(12'h301, 1'b0, 0);
        send(12'h512, 1'b0, 0);
        send(12'h223, 1'b1, 0);
        @(negedge clk);
        check("basic_valid_latency", 64'(valid_out), 64'd1);
        check("basic_n", 64'(n), 64'd4);
        check("basic_e", 64'(e), 64'd3);
        check("basic_data_lo", 64'(data[35:0]), 64'h223512301);
        check("basic_data_hi_zero", 64'(|data[DATA_W-1:36]), 64'd0);
        handoff(0);

        // Backpressure: 10 cycles with ready low, model checks stability
        begin_graph(4'd5);
        send(12'h710, 1'b0, 1);
        send(12'h924, 1'b1, 0);
        wait_valid();
        handoff(10);
        @(negedge clk);
        check("bp_idle_edge_ready", 64'(edge_ready), 64'd0);
        check("bp_idle_valid", 64'(valid_out), 64'd0);
        check("bp_held_e", 64'(e), 64'd2);
        tick();

        // Range check
        begin_graph(4'd3);
        send(12'h421, 1'b0, 0);
        send(12'h130, 1'b1, 0);
        wait_valid();
        check("range_slot0", 64'(data[11:0]), 64'h421);
        check("range_e", 64'(e), RC ? 64'd1 : 64'd2);
        check("range_err", 64'(err), RC ? 64'd1 : 64'd0);
        handoff(1);

        // Randomized graphs, with edges offered in IDLE and start pulses in LOAD/DONE
        for (int g = 0; g < 30; g++) begin
            int nn;
            int cnt;
            nn  = $urandom_range(0, 15);
            cnt = $urandom_range(1, 20);
            edge_valid = 1'b1;
            edge_in    = 12'($urandom);
            edge_last  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) tick();
            edge_valid = 1'b0;
            edge_last  = 1'b0;
            begin_graph(4'(nn));
            for (int i = 0; i < cnt; i++) begin
                logic [11:0] w;
                w = 12'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    w[3:0] = 4'($urandom_range(0, (nn > 0) ? nn - 1 : 0));
                    w[7:4] = 4'($urandom_range(0, (nn > 0) ? nn - 1 : 0));
                end
                send(w, i == cnt - 1, $urandom_range(0, 2));
            end
            wait_valid();
            handoff($urandom_range(0, 4));
        end

        // Capacity: 255 edges without edge_last
        begin_graph(4'd15);
        for (int i = 0; i < MAXE; i++) begin
            logic [11:0] w;
            w = {4'(i % 16), 4'(i % 15), 4'((i / 15) % 15)};
            send(w, 1'b0, 0);
        end
        edge_valid = 1'b1;
        edge_in    = 12'h0AB;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("cap_256th_not_acked", 64'(edge_ready), 64'd0);
            tick();
        end
        edge_valid = 1'b0;
        @(negedge clk);
        check("cap_e", 64'(e), 64'd255);
        check("cap_full", 64'(full), 64'd1);
        check("cap_slot254", 64'(data[254*EDGE_W +: EDGE_W]), 64'hEE1);
        handoff(0);

        // Mid-load reset
        begin_graph(4'd8);
        for (int i = 0; i < 5; i++) send(12'h010 + 12'(i), 1'b0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_n", 64'(n), 64'd0);
        check("rst_e", 64'(e), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_data_any", 64'(|data), 64'd0);
        tick();
        begin_graph(4'd8);
        send(12'h621, 1'b1, 0);
        wait_valid();
        check("rst_fresh_e", 64'(e), 64'd1);
        handoff(0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dijkstra_edge_loader
